bpu_resolver: RTL and testbench
===============================

BPU_RESOLVER -- requirements
Module: bpu_resolver

Interface
REQ-001 Parameters SHALL be: PC_WIDTH, default 32, address width; DEPTH, default 4 (power of two), in-flight prediction queue entries; FLUSH_CYCLES, default 2, cycles flush is held after a mispredict.
REQ-002 The block SHALL have one clock, clk, and an asynchronous, active-low reset, reset_n; ports follow, clock and reset first:
REQ-003 clk  input  1  sole clock, all state on posedge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 fetch_valid  input  1  IF stage issues an instruction with a prediction.
REQ-006 fetch_pc  input  PC_WIDTH  PC of the issued instruction.
REQ-007 fetch_pred_pc  input  PC_WIDTH  predicted next PC supplied by the predictor.
REQ-008 fetch_ready  output  1  queue can accept; combinational: state RUN and count < DEPTH.
REQ-009 resolve_valid  input  1  MEM stage resolves the oldest in-flight instruction.
REQ-010 resolve_pc  input  PC_WIDTH  PC of the resolving instruction.
REQ-011 resolve_next_pc  input  PC_WIDTH  actual next PC.
REQ-012 bpu_w_en  output  1  registered one-cycle predictor update strobe.
REQ-013 tag_pc  output  PC_WIDTH  registered PC of the last resolved instruction.
REQ-014 next_pc  output  PC_WIDTH  registered actual next PC of the last resolved instruction.
REQ-015 redirect_valid  output  1  registered one-cycle fetch redirect.
REQ-016 redirect_pc  output  PC_WIDTH  registered redirect target.
REQ-017 flush  output  1  kill IF/ID and ID/EX contents.
REQ-018 resolve_count  output  16  saturating count of accepted resolves.
REQ-019 mispredict_count  output  16  saturating count of mispredicts.
REQ-020 order_error  output  1  sticky protocol-violation flag.

Function
REQ-021 Push SHALL occur on fetch_valid && fetch_ready, writing {fetch_pc, fetch_pred_pc} at the tail; fetch_valid while fetch_ready is low SHALL be ignored.
REQ-022 A resolve SHALL be accepted when resolve_valid, state RUN and count > 0; it pops the head entry.
REQ-023 resolve_valid with count == 0 in RUN, or with head.pc != resolve_pc, SHALL set order_error; an empty-queue resolve pops nothing, and a PC-mismatch resolve still pops.
REQ-024 Push and accepted resolve in the same cycle SHALL both occur; count unchanged; push when full plus pop SHALL NOT occur (fetch_ready already low).
REQ-025 Each accepted resolve SHALL load tag_pc <= resolve_pc and next_pc <= resolve_next_pc on the next edge and increment resolve_count, saturating at 16'hFFFF.
REQ-026 Mispredict: accepted resolve with head.pred_pc != resolve_next_pc; next cycle bpu_w_en=1, redirect_valid=1, redirect_pc=resolve_next_pc, mispredict_count+1 (saturating).
REQ-027 On mispredict the queue SHALL clear (head=tail=count=0) and any same-cycle push SHALL be discarded as wrong-path.
REQ-028 States: RUN and FLUSH; RUN->FLUSH on mispredict; FLUSH holds exactly FLUSH_CYCLES cycles via down-counter, then ->RUN.
REQ-029 flush SHALL be 1 exactly during FLUSH; fetch_ready SHALL be 0 in FLUSH; resolve_valid in FLUSH SHALL be ignored without setting order_error.
REQ-030 Correct prediction SHALL leave bpu_w_en=0, redirect_valid=0; queue pointers wrap modulo DEPTH.

Reset
REQ-031 reset_n low SHALL immediately force: state RUN, count/pointers 0, bpu_w_en=0, redirect_valid=0, redirect_pc=0, tag_pc=0, next_pc=0, flush=0, counters 0, order_error=0; queue storage contents need not be cleared.
REQ-032 Reset asserted mid-FLUSH SHALL abort the flush; first cycle after release is RUN with fetch_ready=1.

Structure
REQ-033 PC_WIDTH, counter width 16 and the state encoding SHALL live in the shared pipeline package.
REQ-034 The queue SHALL be one sub-module, pred_fifo (push/pop/clear, full/empty, count).

Verification
REQ-035 Push {0x100,0x104},{0x104,0x200}; resolve 0x100->0x104, 0x104->0x200 -> no bpu_w_en, resolve_count=2, mispredict_count=0.
REQ-036 Push {0x200,0x204}; resolve 0x200->0x300 -> next cycle bpu_w_en=1, tag_pc=0x200, next_pc=0x300, redirect_pc=0x300; flush high 2 cycles; fetch_ready 0 then 1.
REQ-037 Push 4 entries, fifth fetch_valid -> fetch_ready=0, fifth dropped; simultaneous push and resolve at count 3 -> count stays 3.
REQ-038 Mispredict cycle with concurrent push {0x400,0x404} -> queue empty after, later resolve_valid in RUN sets order_error.
REQ-039 resolve 0x500 while head.pc=0x504 -> order_error=1, entry popped; stays 1 until reset.
REQ-040 reset_n low during FLUSH -> flush=0 immediately, counters 0, fetch_ready=1 after release.

Source files
------------

// File: rtl/bpu_resolver_pkg.sv
// Shared pipeline definitions for the branch-prediction resolver: widths,
// resolver state encoding and a saturating counter helper.
package bpu_resolver_pkg;

  localparam int unsigned DEF_PC_WIDTH = 32;
  localparam int unsigned CNT_WIDTH    = 16;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } resolver_state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/pred_fifo.sv
// In-flight prediction queue: power-of-two circular buffer with push, pop and
// a synchronous clear that takes precedence over both.
module pred_fifo
  import bpu_resolver_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     clear,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full      = (cnt == (AW+1)'(DEPTH));
  assign empty     = (cnt == '0);
  assign count     = cnt;
  assign head_data = mem[head];
  assign do_push   = push && !full && !clear;
  assign do_pop    = pop && !empty && !clear;

  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (clear) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) tail <= tail + AW'(1);
      if (do_pop)  head <= head + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/bpu_resolver.sv
// Matches MEM-stage branch resolutions against queued IF-stage predictions,
// strobes predictor updates and drives redirect/flush on a mispredict.
module bpu_resolver
  import bpu_resolver_pkg::*;
#(
  parameter int unsigned PC_WIDTH     = DEF_PC_WIDTH,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 fetch_valid,
  input  logic [PC_WIDTH-1:0]  fetch_pc,
  input  logic [PC_WIDTH-1:0]  fetch_pred_pc,
  output logic                 fetch_ready,
  input  logic                 resolve_valid,
  input  logic [PC_WIDTH-1:0]  resolve_pc,
  input  logic [PC_WIDTH-1:0]  resolve_next_pc,
  output logic                 bpu_w_en,
  output logic [PC_WIDTH-1:0]  tag_pc,
  output logic [PC_WIDTH-1:0]  next_pc,
  output logic                 redirect_valid,
  output logic [PC_WIDTH-1:0]  redirect_pc,
  output logic                 flush,
  output logic [CNT_WIDTH-1:0] resolve_count,
  output logic [CNT_WIDTH-1:0] mispredict_count,
  output logic                 order_error
);

  localparam int unsigned FCW = $clog2(FLUSH_CYCLES + 1);

  resolver_state_t         state;
  logic [FCW-1:0]          flush_cnt;
  logic [2*PC_WIDTH-1:0]   head_data;
  logic [PC_WIDTH-1:0]     head_pc;
  logic [PC_WIDTH-1:0]     head_pred_pc;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    resolve_in_run;
  logic                    accept;
  logic                    mispredict;
  logic                    order_violation;
  logic                    push;

  assign head_pc         = head_data[2*PC_WIDTH-1:PC_WIDTH];
  assign head_pred_pc    = head_data[PC_WIDTH-1:0];
  assign fetch_ready     = (state == ST_RUN) && !fifo_full;
  assign resolve_in_run  = resolve_valid && (state == ST_RUN);
  assign accept          = resolve_in_run && (fifo_count != '0);
  assign mispredict      = accept && (head_pred_pc != resolve_next_pc);
  assign order_violation = resolve_in_run && (fifo_empty || (head_pc != resolve_pc));
  // A push landing in the mispredict cycle is wrong-path and must not survive the clear.
  assign push            = fetch_valid && fetch_ready && !mispredict;
  assign flush           = (state == ST_FLUSH);

  pred_fifo #(
    .WIDTH (2*PC_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data ({fetch_pc, fetch_pred_pc}),
    .pop       (accept),
    .clear     (mispredict),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_RUN;
      flush_cnt        <= '0;
      bpu_w_en         <= 1'b0;
      redirect_valid   <= 1'b0;
      redirect_pc      <= '0;
      tag_pc           <= '0;
      next_pc          <= '0;
      resolve_count    <= '0;
      mispredict_count <= '0;
      order_error      <= 1'b0;
    end else begin
      bpu_w_en       <= mispredict;
      redirect_valid <= mispredict;
      if (order_violation) order_error <= 1'b1;
      if (accept) begin
        tag_pc        <= resolve_pc;
        next_pc       <= resolve_next_pc;
        resolve_count <= sat_inc(resolve_count);
      end
      if (mispredict) begin
        redirect_pc      <= resolve_next_pc;
        mispredict_count <= sat_inc(mispredict_count);
      end
      case (state)
        ST_RUN: begin
          if (mispredict) begin
            state     <= ST_FLUSH;
            flush_cnt <= FCW'(FLUSH_CYCLES - 1);
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == '0) state <= ST_RUN;
          else                 flush_cnt <= flush_cnt - FCW'(1);
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_bpu_resolver.sv
// Directed bench for bpu_resolver with hand-computed expectations.
module tb_bpu_resolver;

  logic        clk;
  logic        reset_n;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_pred_pc;
  logic        fetch_ready;
  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic [31:0] resolve_next_pc;
  logic        bpu_w_en;
  logic [31:0] tag_pc;
  logic [31:0] next_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [15:0] resolve_count;
  logic [15:0] mispredict_count;
  logic        order_error;

  int passed = 0;
  int total  = 0;

  bpu_resolver #(
    .PC_WIDTH     (32),
    .DEPTH        (4),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .fetch_valid      (fetch_valid),
    .fetch_pc         (fetch_pc),
    .fetch_pred_pc    (fetch_pred_pc),
    .fetch_ready      (fetch_ready),
    .resolve_valid    (resolve_valid),
    .resolve_pc       (resolve_pc),
    .resolve_next_pc  (resolve_next_pc),
    .bpu_w_en         (bpu_w_en),
    .tag_pc           (tag_pc),
    .next_pc          (next_pc),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .flush            (flush),
    .resolve_count    (resolve_count),
    .mispredict_count (mispredict_count),
    .order_error      (order_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fetch(input logic v, input logic [31:0] pc, input logic [31:0] pred);
    fetch_valid = v; fetch_pc = pc; fetch_pred_pc = pred;
  endtask

  task automatic set_resolve(input logic v, input logic [31:0] pc, input logic [31:0] npc);
    resolve_valid = v; resolve_pc = pc; resolve_next_pc = npc;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_fetch(1'b0, 32'h0, 32'h0);
    set_resolve(1'b0, 32'h0, 32'h0);
    #1;
    total++; if (fetch_ready !== 1'b1) $display("FAIL rst_ready: got %0h want 1", fetch_ready); else passed++;
    cycle(); cycle();
    total++;
    if ({bpu_w_en, redirect_valid, flush, order_error} !== 4'b0 || tag_pc !== 32'h0 || next_pc !== 32'h0 ||
        redirect_pc !== 32'h0 || resolve_count !== 16'h0 || mispredict_count !== 16'h0)
      $display("FAIL rst_outputs: got wen=%0h rv=%0h fl=%0h oe=%0h tag=%0h npc=%0h rpc=%0h rc=%0h mc=%0h want all 0",
               bpu_w_en, redirect_valid, flush, order_error, tag_pc, next_pc, redirect_pc, resolve_count, mispredict_count);
    else passed++;
    reset_n = 1'b1;
    cycle();
    total++; if (fetch_ready !== 1'b1) $display("FAIL rst_release_ready: got %0h want 1", fetch_ready); else passed++;
  endtask

  task automatic test_correct_predictions();
    set_fetch(1'b1, 32'h100, 32'h104); cycle();
    set_fetch(1'b1, 32'h104, 32'h200); cycle();
    set_fetch(1'b0, 32'h0, 32'h0);
    set_resolve(1'b1, 32'h100, 32'h104); cycle();
    total++; if (tag_pc !== 32'h100 || next_pc !== 32'h104) $display("FAIL ok1_tag: got %0h/%0h want 100/104", tag_pc, next_pc); else passed++;
    total++; if (bpu_w_en !== 1'b0) $display("FAIL ok1_wen: got %0h want 0", bpu_w_en); else passed++;
    set_resolve(1'b1, 32'h104, 32'h200); cycle();
    set_resolve(1'b0, 32'h0, 32'h0);
    total++; if (tag_pc !== 32'h104 || next_pc !== 32'h200) $display("FAIL ok2_tag: got %0h/%0h want 104/200", tag_pc, next_pc); else passed++;
    total++; if (bpu_w_en !== 1'b0 || redirect_valid !== 1'b0) $display("FAIL ok2_wen: got %0h/%0h want 0/0", bpu_w_en, redirect_valid); else passed++;
    total++; if (resolve_count !== 16'd2) $display("FAIL ok_rcount: got %0d want 2", resolve_count); else passed++;
    total++; if (mispredict_count !== 16'd0) $display("FAIL ok_mcount: got %0d want 0", mispredict_count); else passed++;
    total++; if (order_error !== 1'b0) $display("FAIL ok_oerr: got %0h want 0", order_error); else passed++;
  endtask

  task automatic test_mispredict();
    set_fetch(1'b1, 32'h200, 32'h204); cycle();
    set_fetch(1'b0, 32'h0, 32'h0);
    set_resolve(1'b1, 32'h200, 32'h300); cycle();
    total++; if (bpu_w_en !== 1'b1 || redirect_valid !== 1'b1) $display("FAIL mp_strobe: got %0h/%0h want 1/1", bpu_w_en, redirect_valid); else passed++;
    total++; if (tag_pc !== 32'h200 || next_pc !== 32'h300 || redirect_pc !== 32'h300)
      $display("FAIL mp_pcs: got tag=%0h npc=%0h rpc=%0h want 200/300/300", tag_pc, next_pc, redirect_pc); else passed++;
    total++; if (flush !== 1'b1 || fetch_ready !== 1'b0) $display("FAIL mp_flush1: got fl=%0h rdy=%0h want 1/0", flush, fetch_ready); else passed++;
    total++; if (mispredict_count !== 16'd1 || resolve_count !== 16'd3) $display("FAIL mp_counts: got %0d/%0d want 1/3", mispredict_count, resolve_count); else passed++;
    // resolve presented during FLUSH must be ignored
    set_resolve(1'b1, 32'h999, 32'h99C); cycle();
    set_resolve(1'b0, 32'h0, 32'h0);
    total++; if (bpu_w_en !== 1'b0 || redirect_valid !== 1'b0) $display("FAIL mp_strobe_drop: got %0h/%0h want 0/0", bpu_w_en, redirect_valid); else passed++;
    total++; if (flush !== 1'b1 || fetch_ready !== 1'b0) $display("FAIL mp_flush2: got fl=%0h rdy=%0h want 1/0", flush, fetch_ready); else passed++;
    total++; if (order_error !== 1'b0 || resolve_count !== 16'd3) $display("FAIL mp_flush_ignore: got oe=%0h rc=%0d want 0/3", order_error, resolve_count); else passed++;
    cycle();
    total++; if (flush !== 1'b0 || fetch_ready !== 1'b1) $display("FAIL mp_flush_end: got fl=%0h rdy=%0h want 0/1", flush, fetch_ready); else passed++;
  endtask

  task automatic test_full_queue();
    for (int i = 0; i < 4; i++) begin
      set_fetch(1'b1, 32'h600 + 32'(4*i), 32'h604 + 32'(4*i)); cycle();
    end
    total++; if (fetch_ready !== 1'b0) $display("FAIL full_ready: got %0h want 0", fetch_ready); else passed++;
    set_fetch(1'b1, 32'h610, 32'h614); cycle();
    total++; if (dut.fifo_count !== 3'd4) $display("FAIL full_drop: got %0d want 4", dut.fifo_count); else passed++;
    set_resolve(1'b1, 32'h600, 32'h604); cycle();
    total++; if (dut.fifo_count !== 3'd3 || fetch_ready !== 1'b1) $display("FAIL full_pop: got cnt=%0d rdy=%0h want 3/1", dut.fifo_count, fetch_ready); else passed++;
    set_resolve(1'b1, 32'h604, 32'h608); cycle();
    set_fetch(1'b0, 32'h0, 32'h0);
    total++; if (dut.fifo_count !== 3'd3) $display("FAIL push_pop_same: got %0d want 3", dut.fifo_count); else passed++;
    set_resolve(1'b1, 32'h608, 32'h60C); cycle();
    set_resolve(1'b1, 32'h60C, 32'h610); cycle();
    set_resolve(1'b1, 32'h610, 32'h614); cycle();
    set_resolve(1'b0, 32'h0, 32'h0);
    total++; if (tag_pc !== 32'h610 || order_error !== 1'b0) $display("FAIL wrap_order: got tag=%0h oe=%0h want 610/0", tag_pc, order_error); else passed++;
    total++; if (resolve_count !== 16'd8 || mispredict_count !== 16'd1) $display("FAIL wrap_counts: got %0d/%0d want 8/1", resolve_count, mispredict_count); else passed++;
    total++; if (dut.fifo_count !== 3'd0) $display("FAIL wrap_empty: got %0d want 0", dut.fifo_count); else passed++;
  endtask

  task automatic test_wrong_path_push();
    set_fetch(1'b1, 32'h700, 32'h704); cycle();
    set_fetch(1'b1, 32'h400, 32'h404);
    set_resolve(1'b1, 32'h700, 32'h800); cycle();
    set_fetch(1'b0, 32'h0, 32'h0);
    set_resolve(1'b0, 32'h0, 32'h0);
    total++; if (dut.fifo_count !== 3'd0) $display("FAIL wp_cleared: got %0d want 0", dut.fifo_count); else passed++;
    total++; if (redirect_pc !== 32'h800 || mispredict_count !== 16'd2) $display("FAIL wp_redirect: got %0h/%0d want 800/2", redirect_pc, mispredict_count); else passed++;
    cycle(); cycle();
    set_resolve(1'b1, 32'h400, 32'h404); cycle();
    set_resolve(1'b0, 32'h0, 32'h0);
    total++; if (order_error !== 1'b1) $display("FAIL wp_oerr: got %0h want 1", order_error); else passed++;
    total++; if (resolve_count !== 16'd9 || bpu_w_en !== 1'b0) $display("FAIL wp_nopop: got rc=%0d wen=%0h want 9/0", resolve_count, bpu_w_en); else passed++;
  endtask

  task automatic test_reset_in_flush();
    set_fetch(1'b1, 32'h900, 32'h904); cycle();
    set_fetch(1'b0, 32'h0, 32'h0);
    set_resolve(1'b1, 32'h900, 32'hA00); cycle();
    set_resolve(1'b0, 32'h0, 32'h0);
    total++; if (flush !== 1'b1) $display("FAIL rf_inflush: got %0h want 1", flush); else passed++;
    reset_n = 1'b0;
    #1;
    total++;
    if (flush !== 1'b0 || resolve_count !== 16'h0 || mispredict_count !== 16'h0 || order_error !== 1'b0 ||
        bpu_w_en !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 32'h0 || tag_pc !== 32'h0)
      $display("FAIL rf_async: got fl=%0h rc=%0d mc=%0d oe=%0h wen=%0h rv=%0h rpc=%0h tag=%0h want all 0",
               flush, resolve_count, mispredict_count, order_error, bpu_w_en, redirect_valid, redirect_pc, tag_pc);
    else passed++;
    cycle();
    reset_n = 1'b1;
    cycle();
    total++; if (fetch_ready !== 1'b1 || flush !== 1'b0) $display("FAIL rf_release: got rdy=%0h fl=%0h want 1/0", fetch_ready, flush); else passed++;
  endtask

  task automatic test_pc_mismatch();
    set_fetch(1'b1, 32'h504, 32'h508); cycle();
    set_fetch(1'b1, 32'h50C, 32'h510); cycle();
    set_fetch(1'b0, 32'h0, 32'h0);
    set_resolve(1'b1, 32'h500, 32'h508); cycle();
    total++; if (order_error !== 1'b1) $display("FAIL pm_oerr: got %0h want 1", order_error); else passed++;
    total++; if (dut.fifo_count !== 3'd1 || resolve_count !== 16'd1) $display("FAIL pm_popped: got cnt=%0d rc=%0d want 1/1", dut.fifo_count, resolve_count); else passed++;
    set_resolve(1'b1, 32'h50C, 32'h510); cycle();
    set_resolve(1'b0, 32'h0, 32'h0);
    cycle(); cycle(); cycle();
    total++; if (order_error !== 1'b1 || resolve_count !== 16'd2) $display("FAIL pm_sticky: got oe=%0h rc=%0d want 1/2", order_error, resolve_count); else passed++;
    total++; if (bpu_w_en !== 1'b0 || mispredict_count !== 16'd0) $display("FAIL pm_nomp: got wen=%0h mc=%0d want 0/0", bpu_w_en, mispredict_count); else passed++;
  endtask

  initial begin
    test_reset();
    test_correct_predictions();
    test_mispredict();
    test_full_queue();
    test_wrong_path_push();
    test_reset_in_flush();
    test_pc_mismatch();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
